// File: rtl/mac_dot_seq.sv
// Streaming dot-product sequencer wrapped around an external combinational mac_unit.
// Define DOT_BEAT_CNT_EN to add the saturating beat counter and the r_count port.
module mac_dot_seq #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_mode,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_a,
  input  logic [DW-1:0] s_b,
  input  logic          s_last,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic [DW-1:0] mac_c,
  output logic          mac_mode,
  input  logic [DW-1:0] mac_out,
  output logic          r_valid,
  input  logic          r_ready,
`ifdef DOT_BEAT_CNT_EN
  output logic [CW-1:0] r_count,
`endif
  output logic [DW-1:0] r_data
);

  typedef enum logic [1:0] {StRun, StDrain, StResult} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          op_valid_q, op_valid_d;
  logic          mode_q, mode_d;
  logic          first_q, first_d;
  logic          accept;

  assign s_ready  = (state_q == StRun) & ~rst;
  assign accept   = s_valid & s_ready;
  assign r_valid  = (state_q == StResult);
  assign r_data   = acc_q;
  assign mac_a    = op_a_q;
  assign mac_b    = op_b_q;
  assign mac_c    = acc_q;
  assign mac_mode = mode_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = 1'b0;
    mode_d     = mode_q;
    first_d    = first_q;

    // Stage 1: register the operand pair; mode is latched only on a vector's first beat.
    if (accept) begin
      op_a_d     = s_a;
      op_b_d     = s_b;
      op_valid_d = 1'b1;
      if (first_q) begin
        mode_d  = cfg_mode;
        first_d = 1'b0;
      end
    end

    // Stage 2: retire the previous beat into the accumulator.
    if (op_valid_q) acc_d = mac_out;

    unique case (state_q)
      StRun: begin
        if (accept && s_last) state_d = StDrain;
      end
      StDrain: begin
        state_d = StResult;
      end
      StResult: begin
        if (r_ready) begin
          state_d = StRun;
          acc_d   = '0;
          first_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      acc_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      mode_q     <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      mode_q     <= mode_d;
      first_q    <= first_d;
    end
  end

`ifdef DOT_BEAT_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (op_valid_q && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
    if ((state_q == StResult) && r_ready) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign r_count = r_valid ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural mac_unit stand-in (INT16 and FP16 a*b+c).
// Compile with DOT_BEAT_CNT_EN defined to also check r_count.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mode, s_valid, s_ready, s_last;
  logic [15:0] s_a, s_b;
  logic [15:0] mac_a, mac_b, mac_c, mac_out;
  logic        mac_mode;
  logic        r_valid, r_ready;
  logic [15:0] r_data;
`ifdef DOT_BEAT_CNT_EN
  logic [7:0]  r_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(.DW(16), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .s_last   (s_last),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_c    (mac_c),
    .mac_mode (mac_mode),
    .mac_out  (mac_out),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
`ifdef DOT_BEAT_CNT_EN
    .r_count  (r_count),
`endif
    .r_data   (r_data)
  );

  // FP16 helpers for normal, finite values only.
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic sgn;
    real  v;
    int   e;
    int   m;
    if (x == 0.0) return 16'h0000;
    sgn = (x < 0.0);
    v   = sgn ? -x : x;
    e   = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = int'((v - 1.0) * 1024.0);
    if (m == 1024) begin m = 0; e++; end
    return {sgn, e[4:0], m[9:0]};
  endfunction

  always_comb begin
    if (mac_mode) mac_out = r2h(h2r(mac_a) * h2r(mac_b) + h2r(mac_c));
    else          mac_out = mac_a * mac_b + mac_c;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic mode);
    int n;
    cfg_mode = mode;
    s_a      = a;
    s_b      = b;
    s_last   = last;
    s_valid  = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called just after the last beat's accepting edge: one DRAIN cycle, then RESULT.
  task automatic expect_result(input string tag, input logic [15:0] data,
                               input logic [7:0] cnt);
    chk({tag, "_drain_rvalid"}, 32'(r_valid), 32'd0);
    chk({tag, "_drain_sready"}, 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_rvalid"}, 32'(r_valid), 32'd1);
    chk({tag, "_rdata"}, 32'(r_data), 32'(data));
`ifdef DOT_BEAT_CNT_EN
    chk({tag, "_rcount"}, 32'(r_count), 32'(cnt));
`else
    if (cnt == 8'hFF) $display("unexpected count marker");
`endif
  endtask

  // Consume the result with r_ready held for two edges: one result only.
  task automatic collect(input string tag);
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rvalid_after"}, 32'(r_valid), 32'd0);
    chk({tag, "_sready_after"}, 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_no_second"}, 32'(r_valid), 32'd0);
    r_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_mode = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_a = '0; s_b = '0; r_ready = 1'b0;
    @(posedge clk);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_rdata", 32'(r_data), 32'd0);
    chk("rst_mac_abc", {mac_a ^ mac_b, mac_c}, 32'd0);
    chk("rst_mac_mode", 32'(mac_mode), 32'd0);
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_sready", 32'(s_ready), 32'd1);

    // INT: 2*3 + 4*5 = 26
    send(16'd2, 16'd3, 1'b0, 1'b0);
    send(16'd4, 16'd5, 1'b1, 1'b0);
    expect_result("int2", 16'h001A, 8'd2);
    collect("int2");

    // FP16: 1*2 + 1*1 = 3.0; cfg_mode flips mid-vector and must be ignored
    send(16'h3C00, 16'h4000, 1'b0, 1'b1);
    send(16'h3C00, 16'h3C00, 1'b1, 1'b0);
    expect_result("fp2", 16'h4200, 8'd2);
    collect("fp2");

    // Single-beat INT, then single-beat FP16 (acc clear and mode relatch)
    send(16'd7, 16'd6, 1'b1, 1'b0);
    expect_result("single_int", 16'h002A, 8'd1);
    collect("single_int");
    send(16'h4000, 16'h4000, 1'b1, 1'b1);
    expect_result("single_fp", 16'h4400, 8'd1);

    // Back-pressure: hold RESULT for 5 cycles while offering a beat
    s_valid = 1'b1; s_a = 16'h1234; s_b = 16'h5678; s_last = 1'b1; cfg_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rvalid", 32'(r_valid), 32'd1);
      chk("bp_rdata", 32'(r_data), 32'h4400);
      chk("bp_sready", 32'(s_ready), 32'd0);
      chk("bp_mac_a", 32'(mac_a), 32'h4000);
    end
    s_valid = 1'b0; s_last = 1'b0;
    collect("bp");

    // Reset mid-vector: three beats pending, then reset
    send(16'd1, 16'd1, 1'b0, 1'b0);
    send(16'd1, 16'd1, 1'b0, 1'b0);
    send(16'd1, 16'd1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid", 32'(r_valid), 32'd0);
    chk("rstmid_acc", 32'(mac_c), 32'd0);
    chk("rstmid_sready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'd1, 16'd1, 1'b1, 1'b0);
    expect_result("rstmid", 16'h0001, 8'd1);

    // Reset while in RESULT: r_valid drops without waiting for a clock
    rst = 1'b1;
    #1;
    chk("rstres_rvalid", 32'(r_valid), 32'd0);
    chk("rstres_rdata", 32'(r_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstres_no_result", 32'(r_valid), 32'd0);

    // Sixteen INT beats (i,1) with random idle gaps: sum 0..15 = 120
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send(16'(i), 16'd1, (i == 15), 1'b0);
    end
    expect_result("gaps16", 16'h0078, 8'd16);
    collect("gaps16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
